// File: rtl/reg_pipe_var.sv
// reg_pipe_var: run-time selectable latency delay line (0..MAX_DEPTH stages)
// with a valid bit per stage, global clock-enable stall and synchronous flush.
// Build option: REG_PIPE_DATA_RST_EN clears the data registers on reset and
// on flush / latency-change edges; without it the data path has no reset so
// it can map onto DSP/SRL resources.
//
// Handshake: out_valid qualifies dout in the same cycle; there is no
// back-pressure, so a word with out_valid=1 is consumed by whoever samples
// it. in_valid qualifies din and is taken on an enabled, non-clearing edge.
module reg_pipe_var #(
    parameter int WIDTH       = 18,
    parameter int MAX_DEPTH   = 4,
    parameter int DEFAULT_LAT = 1,
    parameter int LW          = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             flush,
    input  logic [LW-1:0]    lat_sel,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    output logic             busy,
    output logic [LW-1:0]    lat_q
);

    localparam logic [LW-1:0] MAX_LAT = LW'(MAX_DEPTH);
    localparam logic [LW-1:0] RST_LAT = LW'(DEFAULT_LAT);

    logic [WIDTH-1:0]  r_data [1:MAX_DEPTH];
    logic [MAX_DEPTH:1] r_valid;
    logic [LW-1:0]     r_lat_q;

    logic [LW-1:0]     w_lat_eff;
    logic              w_clear;
    logic [WIDTH-1:0]  w_tap_data [0:MAX_DEPTH];
    logic [MAX_DEPTH:0] w_tap_valid;
    logic              w_busy;

    // Saturate the requested latency; a change of latency empties the pipe.
    always_comb begin
        w_lat_eff = (lat_sel > MAX_LAT) ? MAX_LAT : lat_sel;
        w_clear   = flush | (w_lat_eff != r_lat_q);
    end

    // Latency latch follows the request on every edge, stall or not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lat_q <= RST_LAT;
        end else begin
            r_lat_q <= w_lat_eff;
        end
    end

    // Valid bits: reset and clear beat the enabled shift; otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n || w_clear) begin
            r_valid <= '0;
        end else if (clk_en) begin
            r_valid[1] <= in_valid;
            for (int i = 2; i <= MAX_DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

`ifdef REG_PIPE_DATA_RST_EN
    // Data stages: cleared with the valid bits, shifted on enabled edges.
    always_ff @(posedge clk) begin
        if (!rst_n || w_clear) begin
            for (int i = 1; i <= MAX_DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (clk_en) begin
            r_data[1] <= din;
            for (int i = 2; i <= MAX_DEPTH; i++) begin
                r_data[i] <= r_data[i-1];
            end
        end
    end
`else
    // Data stages: no reset or clear, just shift on enabled edges.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            r_data[1] <= din;
            for (int i = 2; i <= MAX_DEPTH; i++) begin
                r_data[i] <= r_data[i-1];
            end
        end
    end
`endif

    // Tap vector: index 0 is the live input, giving the combinational bypass.
    always_comb begin
        w_tap_data[0] = din;
        for (int i = 1; i <= MAX_DEPTH; i++) begin
            w_tap_data[i] = r_data[i];
        end
        w_tap_valid = {r_valid, in_valid};
    end

    // Busy covers only the stages up to the active tap.
    always_comb begin
        w_busy = 1'b0;
        for (int i = 1; i <= MAX_DEPTH; i++) begin
            if (LW'(i) <= r_lat_q) begin
                w_busy = w_busy | r_valid[i];
            end
        end
    end

    assign dout      = w_tap_data[r_lat_q];
    assign out_valid = w_tap_valid[r_lat_q];
    assign busy      = w_busy;
    assign lat_q     = r_lat_q;

endmodule

// File: tb/tb_reg_pipe_var.sv
// Bench for reg_pipe_var (MAX_DEPTH=4, DEFAULT_LAT=1). The reference model
// tracks accepted words as (data, due enabled-edge count) pairs in queues.
module tb_reg_pipe_var;

  localparam int W    = 18;
  localparam int MAXD = 4;
  localparam int DLAT = 1;
  localparam int LW   = $clog2(MAXD + 1);

  // clock / reset block
  logic          clk = 1'b0;
  logic          rst_n;
  logic          clk_en;
  logic          flush;
  logic [LW-1:0] lat_sel;
  logic [W-1:0]  din;
  logic          in_valid;
  logic [W-1:0]  dout;
  logic          out_valid;
  logic          busy;
  logic [LW-1:0] lat_q;

  always #5 clk = ~clk;

  reg_pipe_var #(.WIDTH(W), .MAX_DEPTH(MAXD), .DEFAULT_LAT(DLAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .flush     (flush),
    .lat_sel   (lat_sel),
    .din       (din),
    .in_valid  (in_valid),
    .dout      (dout),
    .out_valid (out_valid),
    .busy      (busy),
    .lat_q     (lat_q)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  int           m_lat = DLAT;
  int           ecnt  = 0;
  int           n_tests = 0;
  int           n_fail  = 0;
  bit           mon_on  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs, return just after the edge
  task automatic drive(input logic rst, input logic ce, input logic fl,
                       input logic [LW-1:0] ls, input logic v, input logic [W-1:0] d);
    rst_n = rst; clk_en = ce; flush = fl; lat_sel = ls; in_valid = v; din = d;
    @(posedge clk);
    #1;
  endtask

  // reference model: acts on what each edge sees
  initial forever begin
    int le;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      due_q.delete();
      m_lat = DLAT;
    end else begin
      le = (int'(lat_sel) > MAXD) ? MAXD : int'(lat_sel);
      if (flush || le != m_lat) begin
        exp_q.delete();
        due_q.delete();
        m_lat = le;
      end else if (clk_en) begin
        if (due_q.size() > 0 && due_q[0] == ecnt) begin
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
        if (in_valid && m_lat > 0) begin
          exp_q.push_back(din);
          due_q.push_back(ecnt + m_lat);
        end
        ecnt++;
      end
    end
  end

  // monitor: compares outputs every cycle on the falling edge
  initial forever begin
    logic         exp_v;
    logic [W-1:0] exp_d;
    @(negedge clk);
    if (mon_on) begin
      if (m_lat == 0) begin
        exp_v = in_valid;
        exp_d = din;
      end else begin
        exp_v = (due_q.size() > 0) && (due_q[0] == ecnt);
        exp_d = exp_v ? exp_q[0] : '0;
      end
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) chk("dout", 32'(dout), 32'(exp_d));
      chk("busy", 32'(busy), 32'((m_lat != 0) && (exp_q.size() > 0)));
      chk("lat_q", 32'(lat_q), 32'(m_lat));
    end
  end

  // stimulus
  initial begin
    logic [W-1:0]  seq;
    logic [LW-1:0] ls;
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; lat_sel = LW'(DLAT);
    in_valid = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;
    chk("reset_lat_q", 32'(lat_q), 32'(DLAT));
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // stream at latency 3, with a two-cycle stall in the middle
    seq = 1;
    drive(1, 1, 0, 3, 0, '0);
    for (int i = 0; i < 6; i++) begin drive(1, 1, 0, 3, 1, seq); seq++; end
    drive(1, 0, 0, 3, 1, 18'h3ffff);
    drive(1, 0, 0, 3, 1, 18'h3ffff);
    for (int i = 0; i < 6; i++) begin drive(1, 1, 0, 3, 1, seq); seq++; end

    // flush with words in flight; the flush-cycle word must vanish
    drive(1, 1, 1, 3, 1, 18'h0bad);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin drive(1, 1, 0, 3, 1, seq); seq++; end

    // latency change 3 -> 1 mid-stream
    drive(1, 1, 0, 1, 1, seq); seq++;
    chk("latchg_lat_q", 32'(lat_q), 32'd1);
    chk("latchg_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin drive(1, 1, 0, 1, 1, seq); seq++; end

    // bypass, including a reset cycle while in bypass
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 1'($urandom_range(0, 1)), W'($urandom()));
    drive(0, 1, 0, 0, 1, W'($urandom()));
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 1, W'($urandom()));

    // saturated latency request 7 -> 4
    for (int i = 0; i < 8; i++) begin drive(1, 1, 0, 7, 1, seq); seq++; end
    chk("sat_lat_q", 32'(lat_q), 32'(MAXD));

    // reset with words in flight
    drive(0, 1, 0, 7, 1, seq);
    chk("rst_mid_lat_q", 32'(lat_q), 32'(DLAT));
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
`ifdef REG_PIPE_DATA_RST_EN
    chk("rst_mid_dout", 32'(dout), 32'd0);
`endif
    for (int i = 0; i < 8; i++) begin drive(1, 1, 0, 2, 1, seq); seq++; end

    // randomized traffic
    ls = 2;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) ls = LW'($urandom_range(0, 7));
      drive($urandom_range(0, 99) != 0,
            $urandom_range(0, 9) < 8,
            $urandom_range(0, 19) == 0,
            ls,
            $urandom_range(0, 3) != 0,
            W'($urandom()));
    end
    for (int i = 0; i < 6; i++) drive(1, 1, 0, ls, 0, '0);

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
